// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - host byte handshake, shift-register control and serial line of the UART TX sequencer
interface uart_tx_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic [7:0] piso_data;
  logic       piso_load;
  logic       piso_shift;
  logic       piso_bit;
  logic       tx;

  // master: host plus shift register side; slave: the sequencer
  modport master (
    output tx_data, tx_valid, piso_bit,
    input  tx_ready, tx_busy, piso_data, piso_load, piso_shift, tx
  );

  modport slave (
    input  tx_data, tx_valid, piso_bit,
    output tx_ready, tx_busy, piso_data, piso_load, piso_shift, tx
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART TX sequencer: start/data/parity/stop framing over an external LSB-first PISO
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  uart_tx_ctrl_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]    bit_idx_q;
  logic          parity_q;
  logic          tx_ready_q;
  logic          tx_busy_q;

  logic accept;
  logic bit_end;

  assign bit_end = (baud_cnt_q == BAUD_MAX);
  assign accept  = bus.tx_valid & tx_ready_q;

  assign bus.tx_ready   = tx_ready_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.piso_data  = bus.tx_data;
  assign bus.piso_load  = accept;
  assign bus.piso_shift = (state_q == S_DATA) && bit_end;

  // line level is a pure decode of registered state; DATA follows the shift register's bit 0
  assign bus.tx = (state_q == S_START)  ? 1'b0 :
                  (state_q == S_DATA)   ? bus.piso_bit :
                  (state_q == S_PARITY) ? parity_q : 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      parity_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (accept) begin
        state_q    <= S_START;
        baud_cnt_q <= '0;
        bit_idx_q  <= '0;
        parity_q   <= (^bus.tx_data) ^ ODD_BIT;
        tx_ready_q <= 1'b0;
        tx_busy_q  <= 1'b1;
      end
    end else begin
      baud_cnt_q <= bit_end ? '0 : baud_cnt_q + 1'b1;
      if (bit_end) begin
        unique case (state_q)
          S_START: begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
          end
          S_DATA: begin
            if (bit_idx_q == 3'd7) begin
              state_q   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              bit_idx_q <= '0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
          S_PARITY: begin
            state_q   <= S_STOP;
            bit_idx_q <= '0;
          end
          S_STOP: begin
            // bit_idx doubles as the stop-bit index
            if (bit_idx_q == STOP_LAST) begin
              state_q    <= S_IDLE;
              bit_idx_q  <= '0;
              tx_ready_q <= 1'b1;
              tx_busy_q  <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            bit_idx_q  <= '0;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
